// File: rtl/r2r_adc_ctrl.sv
// R2R-ladder ADC conversion controller: SAR (and optional ramp) conversion, block averaging and mV scaling.
// Define R2R_ADC_RAMP_EN to build ramp mode; otherwise every conversion is SAR and successive_approx is ignored.
module r2r_adc_ctrl #(
    parameter int DAC_W         = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int AVG_LOG2      = 4,
    parameter int VREF_MV       = 3300
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             successive_approx,
    input  logic             comp_in,
    output logic [DAC_W-1:0] dac_code,
    output logic [15:0]      raw_out,
    output logic [15:0]      ave_out,
    output logic [15:0]      scaled_out,
    output logic             sample_valid,
    output logic             busy
);

    localparam int SW    = $clog2(SETTLE_CYCLES + 1);
    localparam int BW    = $clog2(DAC_W);
    localparam int SUM_W = DAC_W + AVG_LOG2;
    localparam int PW    = DAC_W + 18;
    localparam logic [DAC_W-1:0] CODE_ONE = DAC_W'(1);
    localparam logic [DAC_W-1:0] CODE_MAX = '1;

    typedef enum logic [1:0] {IDLE, TRIAL, DONE} state_t;

    state_t              state;
    logic                comp_meta;
    logic                comp_s;
    logic [SW-1:0]       settle_cnt;
    logic [BW-1:0]       bit_idx;
    logic [SUM_W-1:0]    sum;
    logic [AVG_LOG2-1:0] count;

    logic                start;
    logic                conv_done;
    logic [DAC_W-1:0]    sar_kept;
    logic [DAC_W-1:0]    conv_result;
    logic [DAC_W-1:0]    next_code;
    logic [SUM_W-1:0]    sum_next;
    logic [PW-1:0]       prod;

`ifdef R2R_ADC_RAMP_EN
    logic                ramp_mode;
`else
    logic                unused_successive_approx;
    assign unused_successive_approx = successive_approx;
`endif

    function automatic logic [DAC_W-1:0] onehot(input logic [BW-1:0] idx);
        return CODE_ONE << idx;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            comp_meta <= 1'b0;
            comp_s    <= 1'b0;
        end else begin
            comp_meta <= comp_in;
            comp_s    <= comp_meta;
        end
    end

    // Decision taken at the last clock of a trial, for whichever mode is latched.
    always_comb begin
        sar_kept    = comp_s ? dac_code : (dac_code & ~onehot(bit_idx));
        conv_done   = (bit_idx == '0);
        conv_result = sar_kept;
        next_code   = sar_kept | onehot(bit_idx - BW'(1));
`ifdef R2R_ADC_RAMP_EN
        if (ramp_mode) begin
            conv_done = 1'b0;
            next_code = dac_code + CODE_ONE;
            if (!comp_s) begin
                conv_done   = 1'b1;
                conv_result = (dac_code == '0) ? '0 : dac_code - CODE_ONE;
            end else if (dac_code == CODE_MAX) begin
                conv_done   = 1'b1;
                conv_result = CODE_MAX;
            end
        end
`endif
        start    = enable && (state != TRIAL);
        sum_next = sum + SUM_W'(conv_result);
        prod     = PW'(ave_out) * PW'(VREF_MV);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            bit_idx      <= '0;
            sum          <= '0;
            count        <= '0;
            dac_code     <= '0;
            raw_out      <= '0;
            ave_out      <= '0;
            scaled_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef R2R_ADC_RAMP_EN
            ramp_mode    <= 1'b0;
`endif
        end else begin
            sample_valid <= 1'b0;
            scaled_out   <= 16'(prod >> DAC_W);
            if (start) begin
                state      <= TRIAL;
                busy       <= 1'b1;
                settle_cnt <= '0;
                bit_idx    <= BW'(DAC_W - 1);
                dac_code   <= onehot(BW'(DAC_W - 1));
`ifdef R2R_ADC_RAMP_EN
                ramp_mode  <= !successive_approx;
                if (!successive_approx)
                    dac_code <= '0;
`endif
            end else if (state == TRIAL) begin
                if (!enable) begin
                    // Abort: partial result and the running block are both dropped.
                    state    <= IDLE;
                    busy     <= 1'b0;
                    dac_code <= '0;
                    sum      <= '0;
                    count    <= '0;
                end else if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                    settle_cnt <= '0;
                    if (conv_done) begin
                        state        <= DONE;
                        dac_code     <= conv_result;
                        raw_out      <= 16'(conv_result);
                        sample_valid <= 1'b1;
                        count        <= count + AVG_LOG2'(1);
                        if (&count) begin
                            ave_out <= 16'(sum_next >> AVG_LOG2);
                            sum     <= '0;
                        end else begin
                            sum <= sum_next;
                        end
                    end else begin
                        dac_code <= next_code;
                        bit_idx  <= bit_idx - BW'(1);
                    end
                end else begin
                    settle_cnt <= settle_cnt + SW'(1);
                end
            end else begin
                state    <= IDLE;
                busy     <= 1'b0;
                dac_code <= '0;
            end
        end
    end

endmodule

// File: tb/tb_r2r_adc_ctrl.sv
// Directed self-checking bench for r2r_adc_ctrl with an ideal comparator (comp_in = vin >= dac_code).
// Ramp scenarios are compiled only when R2R_ADC_RAMP_EN is defined.
`timescale 1ns/1ps
module tb_r2r_adc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        successive_approx = 1'b1;
    logic        comp_in;
    logic [7:0]  vin = 8'h00;
    logic [7:0]  dac_code;
    logic [15:0] raw_out;
    logic [15:0] ave_out;
    logic [15:0] scaled_out;
    logic        sample_valid;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    r2r_adc_ctrl dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .successive_approx(successive_approx),
        .comp_in(comp_in),
        .dac_code(dac_code),
        .raw_out(raw_out),
        .ave_out(ave_out),
        .scaled_out(scaled_out),
        .sample_valid(sample_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;
    assign comp_in = (vin >= dac_code);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts clocks until sample_valid is seen; an expired budget is a failed comparison.
    task automatic waitValid(input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!sample_valid && cycles < budget);
        if (!sample_valid)
            checkOutput("wait_valid_timeout", 32'(sample_valid), 32'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] v, input logic sa);
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;
        vin = v;
        successive_approx = sa;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        enable = 1'b1;
    endtask

    initial begin
        logic [7:0] sar_seq [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        int cyc;
        int pulses;

        #12;
        checkOutput("rst_dac_code", 32'(dac_code), 32'd0);
        checkOutput("rst_raw_out", 32'(raw_out), 32'd0);
        checkOutput("rst_ave_out", 32'(ave_out), 32'd0);
        checkOutput("rst_scaled_out", 32'(scaled_out), 32'd0);
        checkOutput("rst_sample_valid", 32'(sample_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        // SAR trial sequence and first-sample latency for vin = 0xA5
        applyStimulus(8'hA5, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("sar_code_%0d", i), 32'(dac_code), 32'(sar_seq[i]));
            if (i == 7)
                checkOutput("sar_valid_early", 32'(sample_valid), 32'd0);
            repeat (4) tick();
        end
        checkOutput("sar_valid_cycle33", 32'(sample_valid), 32'd1);
        checkOutput("sar_raw", 32'(raw_out), 32'h00A5);
        checkOutput("sar_done_code", 32'(dac_code), 32'hA5);
        checkOutput("sar_busy_done", 32'(busy), 32'd1);

        // Block average over 16 back-to-back samples
        for (int n = 2; n <= 16; n++) begin
            waitValid(40, cyc);
            if (n == 2)
                checkOutput("b2b_interval", 32'(cyc), 32'd33);
            if (n == 15)
                checkOutput("ave_before_block", 32'(ave_out), 32'd0);
        end
        checkOutput("ave_a5", 32'(ave_out), 32'h00A5);
        tick();
        checkOutput("scaled_a5", 32'(scaled_out), 32'd2126);

        // One more sample so the running sum is non-zero, then abort mid-conversion
        waitValid(40, cyc);
        tick();
        repeat (9) tick();
        enable = 1'b0;
        tick();
        checkOutput("abort_dac_code", 32'(dac_code), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_raw_hold", 32'(raw_out), 32'h00A5);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sample_valid)
                pulses++;
        end
        checkOutput("abort_no_valid", 32'(pulses), 32'd0);

        vin = 8'h40;
        @(negedge clk);
        enable = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            waitValid(40, cyc);
            if (n == 1)
                checkOutput("raw_40", 32'(raw_out), 32'h0040);
            if (n == 15)
                checkOutput("ave_hold_a5", 32'(ave_out), 32'h00A5);
        end
        checkOutput("ave_40", 32'(ave_out), 32'h0040);
        tick();
        checkOutput("scaled_40", 32'(scaled_out), 32'd825);

        // Reset asserted mid-trial clears everything asynchronously
        applyStimulus(8'h3C, 1'b1);
        waitValid(40, cyc);
        checkOutput("pre_rst_cycles", 32'(cyc), 32'd33);
        checkOutput("pre_rst_raw", 32'(raw_out), 32'h003C);
        repeat (10) tick();
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_raw", 32'(raw_out), 32'd0);
        checkOutput("midrst_dac_code", 32'(dac_code), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        waitValid(40, cyc);
        checkOutput("post_rst_cycles", 32'(cyc), 32'd33);
        checkOutput("post_rst_raw", 32'(raw_out), 32'h003C);

`ifdef R2R_ADC_RAMP_EN
        // Ramp conversion; mode toggled mid-conversion only affects the next one
        applyStimulus(8'h05, 1'b0);
        tick();
        checkOutput("ramp_start_code", 32'(dac_code), 32'd0);
        repeat (7) tick();
        successive_approx = 1'b1;
        waitValid(60, cyc);
        checkOutput("ramp5_cycles", 32'(cyc), 32'd21);
        checkOutput("ramp5_raw", 32'(raw_out), 32'h0005);
        tick();
        checkOutput("next_is_sar", 32'(dac_code), 32'h80);

        applyStimulus(8'hFF, 1'b0);
        waitValid(1100, cyc);
        checkOutput("rampff_cycles", 32'(cyc), 32'd1025);
        checkOutput("rampff_raw", 32'(raw_out), 32'h00FF);

        applyStimulus(8'h00, 1'b0);
        waitValid(20, cyc);
        checkOutput("ramp0_cycles", 32'(cyc), 32'd9);
        checkOutput("ramp0_raw", 32'(raw_out), 32'h0000);
`else
        // Without ramp support successive_approx=0 still converts by SAR
        applyStimulus(8'h05, 1'b0);
        tick();
        checkOutput("sa_ignored_code", 32'(dac_code), 32'h80);
        waitValid(40, cyc);
        checkOutput("sa_ignored_cycles", 32'(cyc), 32'd32);
        checkOutput("sa_ignored_raw", 32'(raw_out), 32'h0005);
`endif

        enable = 1'b0;
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/r2r_adc_ctrl.md
# r2r_adc_ctrl

Conversion controller for the R2R-ladder ADC channel: drives the R2R DAC code, samples the external comparator, and produces the raw, averaged and scaled 16-bit words the menu subsystem selects for display. It runs only while the menu's R2R enable is high. The menu's successive-approximation select picks SAR or ramp conversion per sample.

## Interface
Parameters:
- DAC_W, 8: R2R DAC width in bits; 4..12.
- SETTLE_CYCLES, 4: clocks each trial code is held. Minimum 3, which covers the 2-FF comparator sync.
- AVG_LOG2, 4: block average over 2^AVG_LOG2 samples.
- VREF_MV, 3300: full-scale reference in mV, used for scaling.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  R2R channel enable from the menu.
- successive_approx  in  1  1 = SAR conversion, 0 = ramp conversion.
- comp_in  in  1  asynchronous comparator. 1 when Vin ≥ V(dac_code).
- dac_code  out  DAC_W  R2R ladder drive.
- raw_out  out  16  last conversion result, zero-extended.
- ave_out  out  16  last block average.
- scaled_out  out  16  ave_out scaled to mV.
- sample_valid  out  1  one-cycle pulse when raw_out updates.
- busy  out  1  high in TRIAL and DONE.

## Operation
- comp_in passes through a 2-FF synchronizer (comp_s) before any use.
- FSM states: IDLE, TRIAL, DONE.
  - IDLE→TRIAL when enable=1. The mode is latched from successive_approx on this transition and held for the whole conversion.
- SAR mode:
  - Trials run from the MSB down to the LSB; each trial drives the result so far with the trial bit set.
  - At the end of each trial the bit is kept if comp_s=1, else cleared.
  - After the LSB trial, go to DONE.
- Ramp mode:
  - Code starts at 0 and increments once per trial while comp_s=1.
  - On the first trial with comp_s=0, result = code−1 (result = 0 if code = 0).
  - If code = 2^DAC_W−1 with comp_s=1, result = 2^DAC_W−1.
- DONE (one cycle):
  - raw_out ← result; sample_valid=1; dac_code holds the result.
  - Accumulate result into the sum and increment the sample count.
  - When the count wraps, ave_out ← (sum + result) >> AVG_LOG2, then the sum is cleared.
  - Then TRIAL if enable=1, else IDLE.
- Scaling: scaled_out ← (ave_out × VREF_MV) >> DAC_W, with a product at least DAC_W+14 bits wide, truncated (no rounding).
- Sum width is DAC_W+AVG_LOG2; it cannot overflow.
- enable falling in TRIAL:
  - abort to IDLE next cycle; dac_code ← 0;
  - the partial result is discarded and there is no sample_valid;
  - sum and count are cleared;
  - raw_out, ave_out and scaled_out hold their values.
- enable falling in DONE: the sample still completes, then IDLE.

## Timing
- Reset values: dac_code, raw_out, ave_out, scaled_out, sample_valid and busy are all 0. FSM is in IDLE with sum and count at 0.
- IDLE: dac_code = 0.
- Trial length is exactly SETTLE_CYCLES clocks. comp_s is sampled on the last clock edge of the trial.
- SAR: sample_valid asserts DAC_W×SETTLE_CYCLES+1 cycles after the cycle in which IDLE sees enable=1.
- Ramp: for result r < 2^DAC_W−1, (r+2)×SETTLE_CYCLES trials' worth of clocks precede DONE.
- Back-to-back conversions: the next TRIAL begins the cycle after DONE. There are no idle cycles.
- ave_out updates in the same cycle as the 2^AVG_LOG2-th sample_valid; scaled_out follows 1 cycle later.
- Asserting reset at any time returns the block to the reset state immediately.

## Configuration
- R2R_ADC_RAMP_EN defined: ramp mode is built and successive_approx selects the mode.
- Undefined: ramp logic is omitted, successive_approx is ignored, and every conversion is SAR.

## Test plan
All scenarios use default parameters. The comparator model is comp_in = (vin ≥ dac_code).
- SAR, vin=0xA5, enable held high → sample_valid at cycle 33 after start; raw_out=0x00A5; dac_code trial sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
- Ramp (macro defined), vin=0x05 → raw_out=0x0005 after 7 trials; vin=0xFF → raw_out=0x00FF; vin=0x00 → raw_out=0x0000.
- 16 SAR samples of vin=0xA5 → ave_out=0x00A5 on the 16th sample_valid; scaled_out=2126 one cycle later.
- enable dropped at cycle 10 of a SAR conversion → no sample_valid; dac_code=0 next cycle; raw_out unchanged. The next 16 samples of 0x40 give ave_out=0x0040 (partial sum discarded).
- successive_approx toggled mid-conversion → the current conversion completes in its latched mode; the next conversion uses the new mode. Without the macro, ramp mode never occurs.
- reset asserted mid-TRIAL → all outputs 0 immediately; after release with enable=1, a fresh conversion yields the correct raw_out.
